// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage program-counter controller.
package pc_ctrl_pkg;

    typedef enum logic [3:0] {
        BOOT  = 4'b0001,
        RUN   = 4'b0010,
        WAIT  = 4'b0100,
        REDIR = 4'b1000
    } pc_state_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle between the fetch controller (slave) and the rest of the pipeline (master).
interface pc_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] PC;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             LoadUseHazard;
    logic             ImemValid;
    logic             ImemReq;
    logic [WIDTH-1:0] PCNext;
    logic             Stall;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output PC, BranchTaken, BranchTarget, LoadUseHazard, ImemValid,
        input  ImemReq, PCNext, Stall, FlushD, FlushE, StallCount
    );

    modport slave (
        input  PC, BranchTaken, BranchTarget, LoadUseHazard, ImemValid,
        output ImemReq, PCNext, Stall, FlushD, FlushE, StallCount
    );
endinterface

// File: rtl/pc_ctrl_stall_counter.sv
// Saturating cycle counter with enable and synchronous reset; sticks at all-ones.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage controller: picks PCNext, stalls PC and IF/ID, flushes D/E, and
// tracks a redirect that lands while an instruction fetch is still outstanding.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
    parameter int               CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_ctrl_if.slave    bus
);

    pc_state_t        state, state_nx;
    logic [WIDTH-1:0] pending, pending_nx;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;
    logic             stall;
    logic             flush_d;
    logic             flush_e;
    logic             imem_req;
    logic [CNT_W-1:0] stall_count;

    assign pc_plus4 = bus.PC + WIDTH'(INSTR_BYTES);

    // Reset must drop Stall so the PC register is free to load the reset vector.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        pc_next    = pc_plus4;
        stall      = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        imem_req   = 1'b0;
        if (rst) begin
            pc_next    = RESET_VEC;
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            pending_nx = '0;
            state_nx   = BOOT;
        end else begin
            case (state)
                BOOT: begin
                    imem_req = 1'b1;
                    state_nx = bus.ImemValid ? RUN : WAIT;
                end
                RUN, WAIT: begin
                    imem_req = 1'b1;
                    if (bus.BranchTaken && (state == RUN)) begin
                        pc_next = bus.BranchTarget;
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (bus.BranchTaken) begin
                        stall      = 1'b1;
                        flush_e    = 1'b1;
                        pending_nx = bus.BranchTarget;
                        state_nx   = REDIR;
                    end else if (!bus.ImemValid) begin
                        stall    = 1'b1;
                        state_nx = WAIT;
                    end else if (bus.LoadUseHazard) begin
                        stall    = 1'b1;
                        flush_e  = 1'b1;
                        state_nx = RUN;
                    end else begin
                        state_nx = RUN;
                    end
                end
                REDIR: begin
                    // The word returning now belongs to the abandoned path; the newest redirect wins.
                    imem_req = 1'b1;
                    stall    = 1'b1;
                    if (bus.BranchTaken) begin
                        pending_nx = bus.BranchTarget;
                        flush_e    = 1'b1;
                    end
                    if (bus.ImemValid) begin
                        stall      = 1'b0;
                        flush_d    = 1'b1;
                        pc_next    = bus.BranchTaken ? bus.BranchTarget : pending;
                        pending_nx = '0;
                        state_nx   = RUN;
                    end
                end
                default: begin
                    state_nx = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pending <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
        end
    end

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (stall),
        .count (stall_count)
    );

    assign bus.PCNext     = pc_next;
    assign bus.Stall      = stall;
    assign bus.FlushD     = flush_d;
    assign bus.FlushE     = flush_e;
    assign bus.ImemReq    = imem_req;
    assign bus.StallCount = stall_count;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-stage controller that sequences the program-counter register of the 5-stage RISC-V core.
- Each cycle it chooses PCNext, drives Stall to the PC register and the IF/ID register, and drives the Decode/Execute flush signals.
- Handles load-use stalls, taken branches and jumps, and multi-cycle instruction-memory responses, including a redirect that arrives while a fetch is outstanding.
- Keeps a saturating counter of stall cycles for performance debug.

Parameters:
- WIDTH, 32, address width of PC, PCNext and BranchTarget.
- RESET_VEC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- PC  in  WIDTH  current value of the PC register.
- BranchTaken  in  1  EX stage resolved a taken branch or a jump.
- BranchTarget  in  WIDTH  redirect target; valid when BranchTaken=1.
- LoadUseHazard  in  1  from the hazard detector; the instruction in D needs a load result still in E.
- ImemValid  in  1  instruction memory returns data for the outstanding fetch this cycle.
- ImemReq  out  1  fetch request for the address on PC.
- PCNext  out  WIDTH  next PC value.
- Stall  out  1  hold the PC register and the IF/ID register.
- FlushD  out  1  clear the IF/ID register (bubble in D).
- FlushE  out  1  clear the ID/EX register (bubble in E).
- StallCount  out  CNT_W  saturating count of cycles with Stall=1.

Behaviour:
- Reset handling:
  - The PC register ignores rst while Stall=1. pc_ctrl must therefore force Stall=0 whenever rst=1, so the PC register can load 0.
  - During rst: PCNext=RESET_VEC, ImemReq=0, FlushD=1, FlushE=1.
  - Next state is BOOT; pending-redirect register is cleared; StallCount=0.
- State machine, one-hot encoded: BOOT, RUN, WAIT, REDIR.
  - BOOT: lasts 1 cycle. ImemReq=1, Stall=0, PCNext=PC+4. Goes to WAIT if ImemValid=0, otherwise to RUN.
  - RUN: ImemReq=1. Priority order, highest first:
    - BranchTaken: PCNext=BranchTarget, Stall=0, FlushD=1, FlushE=1. Any concurrent LoadUseHazard is discarded because its instruction is flushed.
    - ImemValid=0: Stall=1, go to WAIT.
    - LoadUseHazard: Stall=1, FlushE=1, FlushD=0, for exactly one cycle.
    - Otherwise: PCNext=PC+4, Stall=0.
  - WAIT (fetch outstanding): Stall=1, ImemReq held at 1.
    - BranchTaken: latch BranchTarget into the pending register, assert FlushE=1, go to REDIR.
    - ImemValid: the same cycle acts as RUN; the LoadUseHazard rule applies if the hazard is asserted.
  - REDIR: Stall=1 until ImemValid. On ImemValid:
    - Discard the fetched word: FlushD=1.
    - PCNext=pending target, Stall=0, clear pending, go to RUN.
    - A further BranchTaken while in REDIR overwrites the pending target; the last redirect wins.
- Outputs are combinational from state and inputs. Zero-cycle latency from BranchTaken to PCNext.
- Arithmetic:
  - PC+4 is computed modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
  - BranchTarget is not checked for alignment.
- StallCount increments on every cycle with Stall=1 and rst=0, and saturates at all-ones.
- Reset asserted in any state, including mid-WAIT or REDIR, abandons the outstanding fetch and the pending target. A late ImemValid that arrives in BOOT with no request is ignored.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - the state enum pc_state_t {BOOT, RUN, WAIT, REDIR};
  - constant INSTR_BYTES=4;
  - the RESET_VEC default.
- One natural sub-module: stall_counter, a saturating CNT_W counter with enable and sync reset.
- The next-PC select stays inline.

Test Plan:
- Reset release, ImemValid=1 always: PCNext sequence 0,4,8,C; Stall=0 every cycle. Asserting rst while Stall would otherwise be 1 gives Stall=0 and PC returns to 0.
- LoadUseHazard pulsed 1 cycle at PC=0x10: Stall=1 and FlushE=1 for that single cycle, PCNext then 0x14. StallCount=1.
- BranchTaken with BranchTarget=0x200 and LoadUseHazard in the same cycle: PCNext=0x200, FlushD=1, FlushE=1, Stall=0. The hazard is ignored.
- ImemValid held low 3 cycles at PC=0x20: Stall=1 for 3 cycles, ImemReq=1 throughout. On the valid cycle PCNext=0x24. StallCount rises by 3.
- Miss at PC=0x40, BranchTaken to 0x300 in cycle 2, then BranchTaken to 0x400 in cycle 3, ImemValid in cycle 5: fetched word flushed (FlushD=1), PCNext=0x400, then 0x404.
- rst asserted mid-REDIR with pending target 0x300: next cycle is BOOT at 0x0, pending cleared, StallCount=0. Also check PC=0xFFFF_FFFC wraps PCNext to 0x0.
